// File: rtl/fp16_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp16_divider
// Brief    : Multi-cycle FP16 divider (restoring, one quotient bit per cycle).
//            Define FP16_DIV_ROUND_EN for round-to-nearest-even (else truncate).
// Revision : 1.0
// ============================================================================
module fp16_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        dz,
    output logic        ovf,
    output logic        unf
);

`ifdef FP16_DIV_ROUND_EN
    localparam int c_QW = 13;
`else
    localparam int c_QW = 12;
`endif
    localparam logic [3:0] c_LAST = 4'(c_QW - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic [c_QW-1:0] r_q;
    logic [11:0]     r_p;
    logic [3:0]      r_cnt;
    logic            r_done;
    logic [15:0]     r_result;
    logic            r_dz;
    logic            r_ovf;
    logic            r_unf;

    logic        w_sign;
    logic        w_a_zero, w_a_inf, w_b_zero, w_b_inf;
    logic        w_special;
    logic [15:0] w_spec_res;
    logic        w_spec_dz;

    logic [11:0] w_div;
    logic        w_p_ge;
    logic [11:0] w_p_sub;
    logic [11:0] w_p_keep;

    logic               w_top;
    logic [10:0]        w_mant_sum;
    logic signed [6:0]  w_exp_base;
    logic signed [6:0]  w_exp_fin;
    logic [15:0]        w_res;
    logic               w_dz, w_ovf, w_unf;
`ifdef FP16_DIV_ROUND_EN
    logic        w_rem_nz;
    logic [9:0]  w_mant;
    logic        w_rbit;
    logic        w_sticky;
`endif

    assign w_sign   = r_a[15] ^ r_b[15];
    assign w_a_zero = (r_a[14:10] == 5'd0);
    assign w_a_inf  = (r_a[14:10] == 5'h1F);
    assign w_b_zero = (r_b[14:10] == 5'd0);
    assign w_b_inf  = (r_b[14:10] == 5'h1F);

    // Priority order matters: 0/0 and inf/inf first, then x/0 (dz), then the rest.
    always_comb begin
        w_special  = 1'b1;
        w_spec_dz  = 1'b0;
        w_spec_res = {w_sign, 5'h1F, 10'd0};
        if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res = 16'h7E00;
        end else if (w_b_zero) begin
            w_spec_dz  = 1'b1;
        end else if (w_a_zero) begin
            w_spec_res = {w_sign, 15'd0};
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, 5'h1F, 10'd0};
        end else if (w_b_inf) begin
            w_spec_res = {w_sign, 15'd0};
        end else begin
            w_special  = 1'b0;
        end
    end

    // Partial remainder never reaches 2*divisor, so 12 bits are enough.
    assign w_div    = {2'b01, r_b[9:0]};
    assign w_p_ge   = (r_p >= w_div);
    assign w_p_sub  = r_p - w_div;
    assign w_p_keep = w_p_ge ? w_p_sub : r_p;

    assign w_exp_base = $signed({2'b00, r_a[14:10]}) - $signed({2'b00, r_b[14:10]}) + 7'sd15;

    always_comb begin
        w_top = r_q[c_QW-1];
`ifdef FP16_DIV_ROUND_EN
        w_rem_nz = (r_p != 12'd0);
        if (w_top) begin
            w_mant   = r_q[11:2];
            w_rbit   = r_q[1];
            w_sticky = r_q[0] | w_rem_nz;
        end else begin
            w_mant   = r_q[10:1];
            w_rbit   = r_q[0];
            w_sticky = w_rem_nz;
        end
        w_mant_sum = {1'b0, w_mant} + {10'd0, w_rbit & (w_sticky | w_mant[0])};
`else
        w_mant_sum = {1'b0, (w_top ? r_q[10:1] : r_q[9:0])};
`endif
        // A rounding carry-out leaves the fraction at zero and bumps the exponent.
        w_exp_fin = w_exp_base - (w_top ? 7'sd0 : 7'sd1) + (w_mant_sum[10] ? 7'sd1 : 7'sd0);

        w_dz  = 1'b0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (w_special) begin
            w_res = w_spec_res;
            w_dz  = w_spec_dz;
        end else if (w_exp_fin > 7'sd30) begin
            w_res = {w_sign, 5'h1F, 10'd0};
            w_ovf = 1'b1;
        end else if (w_exp_fin < 7'sd1) begin
            w_res = {w_sign, 15'd0};
            w_unf = 1'b1;
        end else begin
            w_res = {w_sign, w_exp_fin[4:0], w_mant_sum[9:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_q     <= '0;
                        r_p     <= {2'b01, a[9:0]};
                        r_cnt   <= '0;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    if (w_special) begin
                        r_state <= c_NORM;
                    end else begin
                        r_q   <= {r_q[c_QW-2:0], w_p_ge};
                        r_p   <= w_p_keep << 1;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_NORM;
                        end
                    end
                end
                c_NORM: begin
                    r_result <= w_res;
                    r_dz     <= w_dz;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                    r_done   <= 1'b1;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == c_CALC) || (r_state == c_NORM);
    assign done   = r_done;
    assign result = r_result;
    assign dz     = r_dz;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp16_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_divider
// Brief    : Scoreboard bench for fp16_divider (directed + random operands).
// Revision : 1.0
// ============================================================================
module tb_fp16_divider;

`ifdef FP16_DIV_ROUND_EN
    localparam int c_NLAT = 15;
    localparam logic [15:0] c_RND_RES = 16'h3C01;
`else
    localparam int c_NLAT = 14;
    localparam logic [15:0] c_RND_RES = 16'h3C00;
`endif

    typedef struct {
        logic [15:0] res;
        logic        dz;
        logic        ovf;
        logic        unf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        dz;
    logic        ovf;
    logic        unf;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fp16_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dz     (dz),
        .ovf    (ovf),
        .unf    (unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [15:0] r, input logic d, input logic o,
                                input logic u, input int lat);
        exp_t e;
        e.res = r; e.dz = d; e.ovf = o; e.unf = u; e.cyc = lat;
        return e;
    endfunction

    // Reference: exact integer quotient of the significands, then normalise/round.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        int   ex, ey, ma, mb, q, mant, e;
        logic s;
`ifdef FP16_DIV_ROUND_EN
        int   rem;
        logic g, st;
`endif
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        r  = mk(16'h0000, 1'b0, 1'b0, 1'b0, 3);
        if ((ex == 0 && ey == 0) || (ex == 31 && ey == 31)) r.res = 16'h7E00;
        else if (ey == 0) begin r.res = {s, 5'h1F, 10'd0}; r.dz = 1'b1; end
        else if (ex == 0)  r.res = {s, 15'd0};
        else if (ex == 31) r.res = {s, 5'h1F, 10'd0};
        else if (ey == 31) r.res = {s, 15'd0};
        else begin
            r.cyc = c_NLAT;
            ma = 1024 + int'(x[9:0]);
            mb = 1024 + int'(y[9:0]);
            e  = ex - ey + 15;
`ifdef FP16_DIV_ROUND_EN
            q   = (ma * 4096) / mb;
            rem = (ma * 4096) % mb;
            if (q >= 4096) begin
                mant = q / 4; g = ((q / 2) % 2) == 1; st = (q % 2) != 0 || rem != 0;
            end else begin
                mant = q / 2; g = (q % 2) == 1; st = rem != 0; e = e - 1;
            end
            if (g && (st || (mant % 2) == 1)) mant = mant + 1;
            if (mant == 2048) begin mant = 1024; e = e + 1; end
`else
            q = (ma * 2048) / mb;
            if (q >= 2048) mant = q / 2;
            else begin mant = q; e = e - 1; end
`endif
            if (e > 30)     begin r.res = {s, 5'h1F, 10'd0}; r.ovf = 1'b1; end
            else if (e < 1) begin r.res = {s, 15'd0};        r.unf = 1'b1; end
            else r.res = {s, 5'(e), 10'(mant)};
        end
        return r;
    endfunction

    // Pushes the expectation, pulses start, optionally spams start while busy,
    // waits (bounded) for done, then returns on a negedge with the DUT in IDLE.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v,
                         input exp_t e, input bit noise);
        exp_t x;
        x     = e;
        x.cyc = cyc + e.cyc;
        sb.push_back(x);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        for (int k = 0; k < 40 && !done; k++) begin
            if (noise && busy && $urandom_range(0, 1) == 1) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout a=%h b=%h: done not seen within 40 cycles", ta, tb_v);
        end
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got result=%h dz=%b ovf=%b unf=%b, none expected",
                             result, dz, ovf, unf);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res || dz !== e.dz || ovf !== e.ovf || unf !== e.unf || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL quotient got result=%h dz=%b ovf=%b unf=%b cyc=%0d expected result=%h dz=%b ovf=%b unf=%b cyc=%0d",
                                 result, dz, ovf, unf, cyc, e.res, e.dz, e.ovf, e.unf, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, dz, ovf, unf} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b result=%h dz=%b ovf=%b unf=%b expected all 0",
                     busy, done, result, dz, ovf, unf);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h4000, 16'h3C00, mk(16'h4000, 0, 0, 0, c_NLAT), 1'b0);
        issue(16'h3C00, 16'h4000, mk(16'h3800, 0, 0, 0, c_NLAT), 1'b0);
        issue(16'h3C00, 16'h4200, mk(16'h3555, 0, 0, 0, c_NLAT), 1'b0);
        issue(16'hBC00, 16'h0000, mk(16'hFC00, 1, 0, 0, 3),      1'b0);
        issue(16'h0000, 16'h0000, mk(16'h7E00, 0, 0, 0, 3),      1'b0);
        issue(16'h7800, 16'h0C00, mk(16'h7C00, 0, 1, 0, c_NLAT), 1'b0);
        issue(16'h0400, 16'h7800, mk(16'h0000, 0, 0, 1, c_NLAT), 1'b0);
        issue(16'h7C00, 16'hFC00, mk(16'h7E00, 0, 0, 0, 3),      1'b0);
        issue(16'hFC00, 16'h3C00, mk(16'hFC00, 0, 0, 0, 3),      1'b0);
        issue(16'h3C00, 16'h7C00, mk(16'h0000, 0, 0, 0, 3),      1'b0);
        issue(16'h8000, 16'h4000, mk(16'h8000, 0, 0, 0, 3),      1'b0);
        issue(16'h3C00, 16'h3BFF, mk(c_RND_RES, 0, 0, 0, c_NLAT), 1'b0);
        issue(16'h4000, 16'h3C00, mk(16'h4000, 0, 0, 0, c_NLAT), 1'b1);

        // Abort mid-CALC: outputs clear at once and no done may follow.
        a = 16'h3C00; b = 16'h4200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, dz, ovf, unf} !== 21'd0) begin
            errors++;
            $display("FAIL midop_reset got busy=%b done=%b result=%h dz=%b ovf=%b unf=%b expected all 0",
                     busy, done, result, dz, ovf, unf);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(16'h3C00, 16'h4000, mk(16'h3800, 0, 0, 0, c_NLAT), 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
            rb = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
            issue(ra, rb, model(ra, rb), (i % 4) == 0);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d pending expectations, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
